// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM state type and alignment helper for dmem_responder
package dmem_pkg;

  localparam logic [1:0] BYTES_WORD = 2'b00;
  localparam logic [1:0] BYTES_HALF = 2'b01;
  localparam logic [1:0] BYTES_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Size code 11 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] bytes, input logic [1:0] addr_lo);
    case (bytes)
      BYTES_BYTE: return 1'b0;
      BYTES_HALF: return addr_lo[0];
      default:    return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - big-endian store lane merge and load extract/extend
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  bytes,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [4:0]  shift;
  logic [31:0] mask;
  logic [31:0] lanes;

  // Lane 0 is the most significant byte, so the shift is (3 - lane) * 8.
  always_comb begin
    shift = 5'd0;
    mask  = 32'hFFFF_FFFF;
    case (bytes)
      BYTES_BYTE: begin
        shift = {~addr_lo, 3'b000};
        mask  = 32'h0000_00FF << shift;
      end
      BYTES_HALF: begin
        shift = {~addr_lo[1], 4'b0000};
        mask  = 32'h0000_FFFF << shift;
      end
      default: ;
    endcase
  end

  always_comb begin
    merged = (old_word & ~mask) | ((wdata << shift) & mask);
    lanes  = (old_word & mask) >> shift;
    case (bytes)
      BYTES_BYTE: rdata = {{24{sign_ext & lanes[7]}}, lanes[7:0]};
      BYTES_HALF: rdata = {{16{sign_ext & lanes[15]}}, lanes[15:0]};
      default:    rdata = lanes;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed access latency and misalign errors
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [1:0]  ReqBytes,
  input  logic        ReqSigned,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        ErrMisalign,
  output logic        Busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            req_write;
  logic [AW+1:0]   req_addr;
  logic [31:0]     req_wdata;
  logic [1:0]      req_bytes;
  logic            req_signed;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     old_word;
  logic [31:0]     merged;
  logic [31:0]     load_data;
  logic            commit;
  logic            unused_addr_hi;

  // Upper address bits are dropped so accesses wrap around the RAM.
  assign unused_addr_hi = ^ReqAddr[31:AW+2];

  assign ReqReady = (state != ST_WAIT);
  assign Busy     = (state == ST_WAIT);
  assign commit   = (state == ST_WAIT) && (cnt == '0);
  assign old_word = mem[req_addr[AW+1:2]];

  dmem_lane_unit u_lane (
    .bytes    (req_bytes),
    .addr_lo  (req_addr[1:0]),
    .sign_ext (req_signed),
    .wdata    (req_wdata),
    .old_word (old_word),
    .merged   (merged),
    .rdata    (load_data)
  );

  always_ff @(posedge Clk) begin
    if (commit && req_write)
      mem[req_addr[AW+1:2]] <= merged;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      RespValid   <= 1'b0;
      RespData    <= '0;
      ErrMisalign <= 1'b0;
      req_write   <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_bytes   <= BYTES_WORD;
      req_signed  <= 1'b0;
    end else begin
      RespValid <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (ReqValid) begin
            req_write  <= ReqWrite;
            req_addr   <= ReqAddr[AW+1:0];
            req_wdata  <= ReqWData;
            req_bytes  <= ReqBytes;
            req_signed <= ReqSigned;
            if (is_misaligned(ReqBytes, ReqAddr[1:0])) begin
              state       <= ST_RESP;
              RespValid   <= 1'b1;
              RespData    <= '0;
              ErrMisalign <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state       <= ST_RESP;
            RespValid   <= 1'b1;
            ErrMisalign <= 1'b0;
            RespData    <= req_write ? 32'd0 : load_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench against a byte-array memory model
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned NBYTE = DEPTH * 4;
  localparam logic [1:0]  SZ_W  = 2'b00;
  localparam logic [1:0]  SZ_H  = 2'b01;
  localparam logic [1:0]  SZ_B  = 2'b10;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [31:0] ReqAddr, ReqWData;
  logic [1:0]  ReqBytes;
  logic        RespValid, ErrMisalign, Busy;
  logic [31:0] RespData;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mb [NBYTE];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqBytes(ReqBytes), .ReqSigned(ReqSigned),
    .RespValid(RespValid), .RespData(RespData), .ErrMisalign(ErrMisalign), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat big-endian byte array; returns load value or applies store.
  task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] by, input logic sg,
                       output logic [31:0] exp_d, output logic exp_e);
    int n;
    int base;
    logic [31:0] v;
    n = (by == SZ_B) ? 1 : (by == SZ_H) ? 2 : 4;
    base = int'(addr % NBYTE);
    exp_e = (base % n) != 0;
    exp_d = 32'd0;
    if (exp_e) return;
    if (wr) begin
      for (int i = 0; i < n; i++)
        mb[base + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++)
        v = (v << 8) | 32'(mb[base + i]);
      if (sg && n < 4 && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8 * n));
      exp_d = v;
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] by, input logic sg);
    ReqWrite = wr; ReqAddr = addr; ReqWData = wd; ReqBytes = by; ReqSigned = sg;
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] by, input logic sg,
                        output logic [31:0] rd);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    int          busy_n;
    model(wr, addr, wd, by, sg, exp_d, exp_e);
    @(negedge Clk);
    drive(wr, addr, wd, by, sg);
    ReqValid = 1'b1;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    n = 0;
    busy_n = 0;
    rd = 32'hx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (Busy) busy_n++;
      if (RespValid) begin
        n = c;
        rd = RespData;
        check({tag, "_err"}, 32'(ErrMisalign), 32'(exp_e));
        break;
      end
    end
    check({tag, "_lat"}, n, exp_e ? 1 : LAT + 1);
    check({tag, "_busy"}, busy_n, exp_e ? 0 : LAT);
    check({tag, "_data"}, rd, exp_d);
  endtask

  logic [31:0] rd;
  logic [31:0] prior;
  int          seen;

  initial begin
    Rst = 1'b0;
    ReqValid = 1'b0;
    drive(1'b0, 32'd0, 32'd0, SZ_W, 1'b0);
    repeat (3) @(negedge Clk);
    check("rst_valid", 32'(RespValid), 0);
    check("rst_data", RespData, 0);
    check("rst_err", 32'(ErrMisalign), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_ready", 32'(ReqReady), 1);
    Rst = 1'b1;

    for (int w = 0; w < 16; w++)
      do_req("init", 1'b1, 32'(w * 4), $urandom, SZ_W, 1'b0, rd);

    do_req("w_st", 1'b1, 32'h10, 32'h1234_5678, SZ_W, 1'b0, rd);
    do_req("w_ld", 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, rd);
    check("w_ld_const", rd, 32'h1234_5678);
    do_req("b_st", 1'b1, 32'h13, 32'h0000_0080, SZ_B, 1'b0, rd);
    do_req("b_word", 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, rd);
    check("b_word_const", rd, 32'h1234_5680);
    do_req("b_sld", 1'b0, 32'h13, 32'h0, SZ_B, 1'b1, rd);
    check("b_sld_const", rd, 32'hFFFF_FF80);
    do_req("b_uld", 1'b0, 32'h13, 32'h0, SZ_B, 1'b0, rd);
    check("b_uld_const", rd, 32'h0000_0080);
    do_req("b_sld11", 1'b0, 32'h11, 32'h0, SZ_B, 1'b1, rd);
    check("b_sld11_const", rd, 32'h0000_0034);
    do_req("h_sld", 1'b0, 32'h12, 32'h0, SZ_H, 1'b1, rd);
    check("h_sld_const", rd, 32'h0000_5680);
    do_req("h_st", 1'b1, 32'h10, 32'h0000_BEEF, SZ_H, 1'b0, rd);
    do_req("h_sld2", 1'b0, 32'h10, 32'h0, SZ_H, 1'b1, rd);
    check("h_sld2_const", rd, 32'hFFFF_BEEF);
    do_req("mis_h", 1'b0, 32'h11, 32'h0, SZ_H, 1'b0, rd);
    check("mis_h_err", 32'(ErrMisalign), 1);
    do_req("mis_w", 1'b1, 32'h12, 32'hCAFE_F00D, SZ_W, 1'b0, rd);
    do_req("mis_chk", 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, rd);
    check("mis_chk_const", rd, 32'hBEEF_5680);
    do_req("wrap", 1'b0, 32'(NBYTE + 32'h10), 32'h0, SZ_W, 1'b0, rd);
    check("wrap_const", rd, 32'hBEEF_5680);

    // Reset mid-WAIT must discard the pending store.
    do_req("pre", 1'b0, 32'h20, 32'h0, SZ_W, 1'b0, prior);
    @(negedge Clk);
    drive(1'b1, 32'h20, 32'hDEAD_BEEF, SZ_W, 1'b0);
    ReqValid = 1'b1;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    @(negedge Clk);
    check("mid_busy", 32'(Busy), 1);
    Rst = 1'b0;
    #1;
    check("ar_busy", 32'(Busy), 0);
    check("ar_ready", 32'(ReqReady), 1);
    check("ar_valid", 32'(RespValid), 0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge Clk);
      if (RespValid) seen++;
    end
    check("ar_no_resp", seen, 0);
    do_req("ar_ld", 1'b0, 32'h20, 32'h0, SZ_W, 1'b0, rd);
    check("ar_ld_prior", rd, prior);

    // Back-to-back: ReqValid stays high, next request presented in the RESP cycle.
    begin
      logic        bw [3];
      logic [31:0] ba [3];
      logic [31:0] bd [3];
      logic [1:0]  bs [3];
      logic        bg [3];
      logic [31:0] be [3];
      logic        ee;
      int idx;
      int gap;
      bw[0] = 1'b1; ba[0] = 32'h30; bd[0] = 32'hA5C3_0F81; bs[0] = SZ_W; bg[0] = 1'b0;
      bw[1] = 1'b0; ba[1] = 32'h33; bd[1] = 32'h0;         bs[1] = SZ_B; bg[1] = 1'b1;
      bw[2] = 1'b0; ba[2] = 32'h30; bd[2] = 32'h0;         bs[2] = SZ_H; bg[2] = 1'b1;
      @(negedge Clk);
      model(bw[0], ba[0], bd[0], bs[0], bg[0], be[0], ee);
      drive(bw[0], ba[0], bd[0], bs[0], bg[0]);
      ReqValid = 1'b1;
      idx = 0;
      gap = 0;
      for (int c = 0; c < 60 && idx < 3; c++) begin
        @(negedge Clk);
        gap++;
        if (RespValid) begin
          check("b2b_gap", gap, LAT + 1);
          check("b2b_data", RespData, be[idx]);
          check("b2b_ready", 32'(ReqReady), 1);
          gap = 0;
          idx++;
          if (idx < 3) begin
            model(bw[idx], ba[idx], bd[idx], bs[idx], bg[idx], be[idx], ee);
            drive(bw[idx], ba[idx], bd[idx], bs[idx], bg[idx]);
          end else begin
            ReqValid = 1'b0;
          end
        end
      end
      ReqValid = 1'b0;
      check("b2b_count", idx, 3);
    end

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 7)) << 12);
      do_req("rnd", 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
